// File: rtl/lcd_bus_scheduler_if.sv
// ---------------------------------------------------------------------------
// lcd_bus_scheduler_if
//   Bundles the two client request channels, the scheduler status flags and
//   the HD44780-class LCD write pins into one interface.
//
//   Client channel N (N = 0, 1):
//     reqN       client has a byte pending
//     rsN        register select for the byte (0 = command, 1 = data)
//     datN[7:0]  byte to write
//     ackN       one-cycle pulse, byte accepted
//   Status:
//     busy       high unless idle with init complete
//     init_done  sticky, set once the power-on init sequence has finished
//   LCD pins:
//     rs, rw, ena, dat[7:0]
//
//   Modports:
//     master  client / pin side (drives requests, observes everything else)
//     slave   scheduler side
// ---------------------------------------------------------------------------
interface lcd_bus_scheduler_if;
   logic       req0;
   logic       rs0;
   logic [7:0] dat0;
   logic       ack0;

   logic       req1;
   logic       rs1;
   logic [7:0] dat1;
   logic       ack1;

   logic       busy;
   logic       init_done;

   logic       rs;
   logic       rw;
   logic       ena;
   logic [7:0] dat;

   modport master (
      output req0, rs0, dat0,
      output req1, rs1, dat1,
      input  ack0, ack1,
      input  busy, init_done,
      input  rs, rw, ena, dat
   );

   modport slave (
      input  req0, rs0, dat0,
      input  req1, rs1, dat1,
      output ack0, ack1,
      output busy, init_done,
      output rs, rw, ena, dat
   );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// ---------------------------------------------------------------------------
// lcd_bus_scheduler
//   Shares one 8-bit HD44780-class LCD write port between two clients.
//   After reset it waits T_PWR cycles, writes the init bytes 0x38, 0x06,
//   0x0C, 0x01 (rs=0), then serves client bytes with round-robin
//   arbitration. Every byte is framed as setup / enable pulse / hold /
//   execution wait; clear and home commands get the long execution wait.
//
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   lcd_bus_scheduler_if.slave (client channels, status, LCD pins)
//
// Parameters (cycle counts, 0 is treated as 1):
//   T_PWR    power-up wait before the first init byte
//   T_SETUP  rs/dat stable with ena=0 before ena rises
//   T_EN     ena high time
//   T_HOLD   rs/dat held after ena falls
//   T_CMD    execution wait for normal commands and data writes
//   T_CLR    execution wait for clear/home commands
//
// State table:
//   state  | meaning
//   -------+---------------------------------------------------------------
//   PWR    | power-up wait, ena=0
//   LOAD   | latch next init byte into rs/dat (1 cycle)
//   IDLE   | init complete, arbitrate between clients
//   SETUP  | rs/dat on the pins, ena=0
//   EN     | ena=1
//   HOLD   | ena=0, rs/dat still held
//   WAIT   | controller execution time for the latched byte
// ---------------------------------------------------------------------------
module lcd_bus_scheduler #(
   parameter int unsigned T_PWR   = 2000000,
   parameter int unsigned T_SETUP = 4,
   parameter int unsigned T_EN    = 25,
   parameter int unsigned T_HOLD  = 4,
   parameter int unsigned T_CMD   = 2500,
   parameter int unsigned T_CLR   = 100000
) (
   input  logic                 clk,
   input  logic                 rst,
   lcd_bus_scheduler_if.slave   bus
);

   localparam int unsigned P_PWR   = (T_PWR   == 0) ? 1 : T_PWR;
   localparam int unsigned P_SETUP = (T_SETUP == 0) ? 1 : T_SETUP;
   localparam int unsigned P_EN    = (T_EN    == 0) ? 1 : T_EN;
   localparam int unsigned P_HOLD  = (T_HOLD  == 0) ? 1 : T_HOLD;
   localparam int unsigned P_CMD   = (T_CMD   == 0) ? 1 : T_CMD;
   localparam int unsigned P_CLR   = (T_CLR   == 0) ? 1 : T_CLR;

   localparam int unsigned M_A   = (P_PWR   > P_CLR)  ? P_PWR   : P_CLR;
   localparam int unsigned M_B   = (P_CMD   > P_EN)   ? P_CMD   : P_EN;
   localparam int unsigned M_C   = (P_SETUP > P_HOLD) ? P_SETUP : P_HOLD;
   localparam int unsigned M_AB  = (M_A > M_B)        ? M_A     : M_B;
   localparam int unsigned T_MAX = (M_AB > M_C)       ? M_AB    : M_C;

   // The counter only ever holds (count - 1), so T_MAX - 1 must fit.
   localparam int CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CW-1:0] LD_PWR   = CW'(P_PWR   - 1);
   localparam logic [CW-1:0] LD_SETUP = CW'(P_SETUP - 1);
   localparam logic [CW-1:0] LD_EN    = CW'(P_EN    - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(P_HOLD  - 1);
   localparam logic [CW-1:0] LD_CMD   = CW'(P_CMD   - 1);
   localparam logic [CW-1:0] LD_CLR   = CW'(P_CLR   - 1);

   localparam logic [2:0] INIT_LEN = 3'd4;

   typedef enum logic [2:0] {
      S_PWR,
      S_LOAD,
      S_IDLE,
      S_SETUP,
      S_EN,
      S_HOLD,
      S_WAIT
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    init_idx;
   logic          last_grant;
   logic          init_done_r;
   logic          rs_r;
   logic          ena_r;
   logic [7:0]    dat_r;

   logic          in_idle;
   logic          any_req;
   logic          grant_sel;
   logic          is_clr;

   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'h38;
         3'd1:    b = 8'h06;
         3'd2:    b = 8'h0C;
         default: b = 8'h01;
      endcase
      return b;
   endfunction

   // Arbitration is a pure decode of the request lines so the grant, the
   // ack pulse and the latch all happen in the single IDLE cycle.
   // grant_sel: 0 = client 0, 1 = client 1; on a tie, the client that did
   // not win last time.
   always_comb begin
      in_idle   = (state == S_IDLE) && init_done_r;
      any_req   = bus.req0 | bus.req1;
      grant_sel = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
      is_clr    = !rs_r && ((dat_r == 8'h01) || (dat_r == 8'h02) || (dat_r == 8'h03));
   end

   // ack is gated by rst because a reset cycle never completes a grant.
   assign bus.ack0      = in_idle && !rst && any_req && !grant_sel;
   assign bus.ack1      = in_idle && !rst && any_req &&  grant_sel;
   assign bus.busy      = !in_idle;
   assign bus.init_done = init_done_r;
   assign bus.rs        = rs_r;
   assign bus.rw        = 1'b0;
   assign bus.ena       = ena_r;
   assign bus.dat       = dat_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_PWR;
         cnt         <= LD_PWR;
         init_idx    <= 3'd0;
         last_grant  <= 1'b1;
         init_done_r <= 1'b0;
         rs_r        <= 1'b0;
         dat_r       <= 8'h00;
         ena_r       <= 1'b0;
      end else begin
         case (state)
            S_PWR: begin
               if (cnt == '0) begin
                  state <= S_LOAD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_LOAD: begin
               rs_r     <= 1'b0;
               dat_r    <= init_byte(init_idx);
               init_idx <= init_idx + 3'd1;
               cnt      <= LD_SETUP;
               state    <= S_SETUP;
            end

            S_IDLE: begin
               if (any_req && init_done_r) begin
                  rs_r       <= grant_sel ? bus.rs1  : bus.rs0;
                  dat_r      <= grant_sel ? bus.dat1 : bus.dat0;
                  last_grant <= grant_sel;
                  cnt        <= LD_SETUP;
                  state      <= S_SETUP;
               end
            end

            S_SETUP: begin
               if (cnt == '0) begin
                  ena_r <= 1'b1;
                  cnt   <= LD_EN;
                  state <= S_EN;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_EN: begin
               if (cnt == '0) begin
                  ena_r <= 1'b0;
                  cnt   <= LD_HOLD;
                  state <= S_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_HOLD: begin
               if (cnt == '0) begin
                  cnt   <= is_clr ? LD_CLR : LD_CMD;
                  state <= S_WAIT;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_WAIT: begin
               if (cnt == '0) begin
                  if (init_idx < INIT_LEN) begin
                     state <= S_LOAD;
                  end else begin
                     init_done_r <= 1'b1;
                     state       <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               ena_r <= 1'b0;
               cnt   <= LD_PWR;
               state <= S_PWR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_scheduler
//   Directed bench for lcd_bus_scheduler with short timing parameters.
//   Stimulus is driven and checked on the falling edge; a monitor sampling
//   just after each rising edge watches rw and rs/dat stability around ena.
// ---------------------------------------------------------------------------
module tb_lcd_bus_scheduler;

   localparam int T_PWR   = 20;
   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_HOLD  = 2;
   localparam int T_CMD   = 10;
   localparam int T_CLR   = 30;

   // Ack cycle to next IDLE: 1 + T_SETUP + T_EN + T_HOLD + wait.
   localparam int COST_CMD = 18;
   localparam int COST_CLR = 38;

   logic clk = 1'b0;
   logic rst;

   lcd_bus_scheduler_if bus_if ();

   lcd_bus_scheduler #(
      .T_PWR   (T_PWR),
      .T_SETUP (T_SETUP),
      .T_EN    (T_EN),
      .T_HOLD  (T_HOLD),
      .T_CMD   (T_CMD),
      .T_CLR   (T_CLR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   int n_tests   = 0;
   int n_fail    = 0;
   int init_acks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor: rw always 0; rs/dat frozen while ena=1 and for T_HOLD
   // cycles after ena falls (reset edges excluded).
   int         hold_left = 0;
   bit         guard     = 1'b0;
   logic       m_rs;
   logic [7:0] m_dat;

   always @(posedge clk) begin
      #2;
      if (rst) begin
         guard     = 1'b0;
         hold_left = 0;
      end else begin
         check("rw_zero", 32'(bus_if.rw), 32'd0);
         if (guard) begin
            check("stable_rs",  32'(bus_if.rs),  32'(m_rs));
            check("stable_dat", 32'(bus_if.dat), 32'(m_dat));
         end
         if (bus_if.ena) hold_left = T_HOLD;
         else if (hold_left > 0) hold_left--;
         guard = bus_if.ena || (hold_left > 0);
         if (!bus_if.init_done && (bus_if.ack0 || bus_if.ack1)) init_acks++;
      end
      m_rs  = bus_if.rs;
      m_dat = bus_if.dat;
   end

   // Called on the falling edge right after rst is released.
   task automatic init_check();
      logic [7:0] exp_b [4];
      int n;
      int w;
      int g;
      exp_b[0] = 8'h38;
      exp_b[1] = 8'h06;
      exp_b[2] = 8'h0C;
      exp_b[3] = 8'h01;
      n = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         n++;
         if (bus_if.ena) break;
      end
      // T_PWR + LOAD + T_SETUP = 20 + 1 + 2
      check("pwr_to_first_ena", 32'(n), 32'd23);
      check("init_done_in_init", 32'(bus_if.init_done), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("init_dat", 32'(bus_if.dat), 32'(exp_b[i]));
         check("init_rs",  32'(bus_if.rs),  32'd0);
         w = 1;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!bus_if.ena) break;
            w++;
         end
         check("init_ena_width", 32'(w), 32'd3);
         g = 1;
         if (i < 3) begin
            for (int k = 0; k < 500; k++) begin
               @(negedge clk);
               if (bus_if.ena) break;
               g++;
            end
            // T_HOLD + T_CMD + LOAD + T_SETUP = 2 + 10 + 1 + 2
            check("init_gap", 32'(g), 32'd15);
         end else begin
            for (int k = 0; k < 500; k++) begin
               @(negedge clk);
               if (!bus_if.busy) break;
               g++;
            end
            // T_HOLD + T_CLR = 2 + 30
            check("clr_gap_to_idle", 32'(g), 32'd32);
         end
      end
      check("init_done_set", 32'(bus_if.init_done), 32'd1);
      check("busy_after_init", 32'(bus_if.busy), 32'd0);
   endtask

   // Called on a falling edge in IDLE with the requests already applied.
   // Ends on the falling edge of the next IDLE cycle.
   task automatic run_byte(input string tag, input logic a0, input logic a1,
                           input logic e_rs, input logic [7:0] e_dat, input int e_cost);
      int n;
      #1;
      check({tag, "_ack0"}, 32'(bus_if.ack0), 32'(a0));
      check({tag, "_ack1"}, 32'(bus_if.ack1), 32'(a1));
      check({tag, "_busy_grant"}, 32'(bus_if.busy), 32'd0);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check({tag, "_rs"},   32'(bus_if.rs),  32'(e_rs));
            check({tag, "_dat"},  32'(bus_if.dat), 32'(e_dat));
            check({tag, "_noack"}, 32'({bus_if.ack0, bus_if.ack1}), 32'd0);
            check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
         end
         if (n == 2) check({tag, "_ena_setup"}, 32'(bus_if.ena), 32'd0);
         if (n == 3) check({tag, "_ena_rise"},  32'(bus_if.ena), 32'd1);
         if (n == 5) check({tag, "_ena_last"},  32'(bus_if.ena), 32'd1);
         if (n == 6) check({tag, "_ena_fall"},  32'(bus_if.ena), 32'd0);
         if (!bus_if.busy) break;
      end
      check({tag, "_cost"}, 32'(n), 32'(e_cost));
   endtask

   initial begin
      rst         = 1'b1;
      bus_if.req0 = 1'b1;
      bus_if.rs0  = 1'b1;
      bus_if.dat0 = 8'h48;
      bus_if.req1 = 1'b1;
      bus_if.rs1  = 1'b1;
      bus_if.dat1 = 8'h42;
      repeat (3) @(negedge clk);

      check("rst_ena",       32'(bus_if.ena),       32'd0);
      check("rst_dat",       32'(bus_if.dat),       32'd0);
      check("rst_rs",        32'(bus_if.rs),        32'd0);
      check("rst_init_done", 32'(bus_if.init_done), 32'd0);
      check("rst_busy",      32'(bus_if.busy),      32'd1);
      check("rst_ack0",      32'(bus_if.ack0),      32'd0);
      rst = 1'b0;

      // Both clients request throughout init.
      init_check();
      check("no_ack_in_init", 32'(init_acks), 32'd0);

      // Round robin with both requests held: 0 wins first tie, then 1, 0, 1.
      run_byte("rr0", 1'b1, 1'b0, 1'b1, 8'h48, COST_CMD);
      bus_if.dat0 = 8'h65;
      run_byte("rr1", 1'b0, 1'b1, 1'b1, 8'h42, COST_CMD);
      bus_if.dat1 = 8'h43;
      run_byte("rr2", 1'b1, 1'b0, 1'b1, 8'h65, COST_CMD);
      run_byte("rr3", 1'b0, 1'b1, 1'b1, 8'h43, COST_CMD);

      // Client 1 alone: wait length depends on the command byte.
      bus_if.req0 = 1'b0;
      bus_if.rs1  = 1'b0;
      bus_if.dat1 = 8'h01;
      run_byte("cmd01", 1'b0, 1'b1, 1'b0, 8'h01, COST_CLR);
      bus_if.dat1 = 8'hC0;
      run_byte("cmdC0", 1'b0, 1'b1, 1'b0, 8'hC0, COST_CMD);
      bus_if.dat1 = 8'h00;
      run_byte("cmd00", 1'b0, 1'b1, 1'b0, 8'h00, COST_CMD);
      bus_if.dat1 = 8'h03;
      run_byte("cmd03", 1'b0, 1'b1, 1'b0, 8'h03, COST_CLR);
      bus_if.rs1  = 1'b1;
      bus_if.dat1 = 8'h01;
      run_byte("data01", 1'b0, 1'b1, 1'b1, 8'h01, COST_CMD);

      // No requests: stay idle, pins keep the last byte.
      bus_if.req1 = 1'b0;
      #1;
      check("idle_ack1", 32'(bus_if.ack1), 32'd0);
      repeat (5) @(negedge clk);
      check("idle_busy", 32'(bus_if.busy), 32'd0);
      check("idle_ena",  32'(bus_if.ena),  32'd0);
      check("idle_dat",  32'(bus_if.dat),  32'h01);
      check("idle_rs",   32'(bus_if.rs),   32'd1);

      // Reset during the enable pulse of a client byte.
      bus_if.req0 = 1'b1;
      bus_if.rs0  = 1'b1;
      bus_if.dat0 = 8'h5A;
      #1;
      check("abort_ack0", 32'(bus_if.ack0), 32'd1);
      repeat (3) @(negedge clk);
      check("abort_in_en",  32'(bus_if.ena), 32'd1);
      check("abort_dat_en", 32'(bus_if.dat), 32'h5A);
      rst         = 1'b1;
      bus_if.req0 = 1'b0;
      @(negedge clk);
      check("abort_ena",       32'(bus_if.ena),       32'd0);
      check("abort_dat",       32'(bus_if.dat),       32'd0);
      check("abort_rs",        32'(bus_if.rs),        32'd0);
      check("abort_init_done", 32'(bus_if.init_done), 32'd0);
      check("abort_busy",      32'(bus_if.busy),      32'd1);
      rst = 1'b0;
      init_check();
      #1;
      check("reinit_ack0", 32'(bus_if.ack0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
